// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: default geometry shared by the RAM-backed FIFO and its storage.
package ram_fifo_pkg;

    // Default data word width in bits.
    localparam int unsigned DEF_WIDTH = 32;

    // Default address width; capacity is 2**DEF_DEPTH words.
    localparam int unsigned DEF_DEPTH = 12;

endpackage

// File: rtl/ram_fifo_dpram.sv
// ram_fifo_dpram: simple dual-port RAM with one synchronous write port and one
// synchronous read port. There is no reset, so it infers block RAM.
module ram_fifo_dpram
    import ram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1 << DEPTH) - 1];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port; the output holds its value while re is low, so it doubles as
    // the FIFO's prefetch register.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_fifo.sv
// ram_fifo: single-clock show-ahead FIFO whose storage is an inferred dual-port
// RAM. The RAM's registered read output acts as the head (prefetch) register;
// head_valid_q marks whether it holds a live word.
module ram_fifo
    import ram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             shift_in,
    input  logic             shift_out,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [DEPTH:0] CAPACITY = {1'b1, {DEPTH{1'b0}}};

    logic [DEPTH-1:0] wptr_q;
    logic [DEPTH-1:0] rptr_q;
    logic [DEPTH:0]   count_q;
    logic [DEPTH:0]   count_d;
    logic [DEPTH:0]   ram_count;
    logic             head_valid_q;
    logic             push;
    logic             pop;
    logic             ram_read;
    logic [WIDTH-1:0] ram_rdata;

    assign full  = (count_q == CAPACITY);
    assign empty = ~head_valid_q;

    // A push attempted while full freezes the whole cycle, so a concurrent pop
    // is suppressed as well.
    assign push = shift_in & ~full;
    assign pop  = shift_out & head_valid_q & ~(shift_in & full);

    // Words still sitting in the RAM (count includes the head register).
    assign ram_count = count_q - {{DEPTH{1'b0}}, head_valid_q};

    // Refill the head whenever it is empty or being consumed and the RAM has data.
    assign ram_read = (ram_count != '0) && (!head_valid_q || pop);

    // The RAM output is undefined after reset, so mask it while no word is held.
    assign rdata = head_valid_q ? ram_rdata : '0;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and head-valid flag.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + DEPTH'(1);
            end
            if (ram_read) begin
                rptr_q <= rptr_q + DEPTH'(1);
            end
            count_q <= count_d;
            if (ram_read) begin
                head_valid_q <= 1'b1;
            end else if (pop) begin
                head_valid_q <= 1'b0;
            end
        end
    end

    ram_fifo_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dpram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q),
        .wdata (wdata),
        .re    (ram_read),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ram_fifo.sv
// tb_ram_fifo: directed stimulus with a scoreboard queue; a negedge monitor
// pops the expected word whenever the DUT accepts a pop and compares rdata.
module tb_ram_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 12;
    localparam int          CAP   = 1 << DEPTH;

    logic             clk;
    logic             res_n;
    logic             shift_in;
    logic             shift_out;
    logic [WIDTH-1:0] wdata;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] rdata;

    logic [WIDTH-1:0] exp_q [$];
    int               checks;
    int               errors;
    int               popped;

    ram_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .shift_in  (shift_in),
        .shift_out (shift_out),
        .wdata     (wdata),
        .full      (full),
        .empty     (empty),
        .rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h required %08h", name, act, req);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic si, input logic so, input logic [WIDTH-1:0] d);
        shift_in  = si;
        shift_out = so;
        wdata     = d;
        @(posedge clk);
        #1;
    endtask

    // Push a word the FIFO is expected to accept.
    task automatic push_word(input logic [WIDTH-1:0] d);
        exp_q.push_back(d);
        cyc(1'b1, 1'b0, d);
    endtask

    // Pop until empty, bounded by a cycle budget.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (empty == 1'b0 && n < budget) begin
            cyc(1'b0, 1'b1, '0);
            n++;
        end
        cyc(1'b0, 1'b0, '0);
        check({name, "_empty"}, {31'd0, empty}, 32'd1);
        check({name, "_left"}, exp_q.size(), 32'd0);
    endtask

    // Monitor: an accepted pop must present the oldest expected word.
    always @(negedge clk) begin
        if (res_n && !empty && shift_out && !(shift_in && full)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_order: got %08h required <no word queued>", rdata);
            end else begin
                check("pop_order", rdata, exp_q.pop_front());
            end
            popped++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic full_seen;
        logic [WIDTH-1:0] first_word;
        checks    = 0;
        errors    = 0;
        popped    = 0;
        res_n     = 1'b0;
        shift_in  = 1'b1;
        shift_out = 1'b1;
        wdata     = 32'hDEAD_BEEF;

        // Reset: shifts during reset are ignored.
        #100;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        shift_in  = 1'b0;
        shift_out = 1'b0;
        @(posedge clk);
        #1;
        res_n = 1'b1;
        cyc(1'b0, 1'b0, '0);
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        // 1024 random words then drain.
        p0        = popped;
        full_seen = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            push_word($urandom);
            full_seen |= full;
        end
        drain("fill1k", 1100);
        check("fill1k_pops", popped - p0, 32'd1024);
        check("fill1k_nofull", {31'd0, full_seen}, 32'd0);

        // Fill to capacity, then attempted overflow pushes.
        p0 = popped;
        for (int i = 0; i < CAP; i++) begin
            if (i == CAP - 1) begin
                check("full_before_last", {31'd0, full}, 32'd0);
            end
            push_word(32'h1000_0000 + i * 3);
        end
        first_word = 32'h1000_0000;
        check("full_after_last", {31'd0, full}, 32'd1);
        cyc(1'b1, 1'b0, 32'hBAD0_0001);
        check("ovf_full", {31'd0, full}, 32'd1);
        cyc(1'b1, 1'b1, 32'hBAD0_0002);
        check("ovf_pop_full", {31'd0, full}, 32'd1);
        check("ovf_head", rdata, first_word);
        cyc(1'b0, 1'b1, '0);
        check("full_falls", {31'd0, full}, 32'd0);
        drain("fill4k", CAP + 10);
        check("fill4k_pops", popped - p0, CAP);

        // Half occupancy with concurrent push and pop; pointers wrap.
        for (int i = 0; i < CAP / 2; i++) begin
            push_word(32'h2000_0000 + i);
        end
        p0 = popped;
        for (int i = 0; i < 5000; i++) begin
            exp_q.push_back(32'h3000_0000 + i);
            cyc(1'b1, 1'b1, 32'h3000_0000 + i);
        end
        check("steady_pops", popped - p0, 32'd5000);
        check("steady_level", exp_q.size(), CAP / 2);
        check("steady_full", {31'd0, full}, 32'd0);
        check("steady_empty", {31'd0, empty}, 32'd0);
        drain("steady", CAP);

        // Fall-through latency and pop on empty.
        exp_q.push_back(32'h0000_ABCD);
        cyc(1'b1, 1'b0, 32'h0000_ABCD);
        check("lat_edge1_empty", {31'd0, empty}, 32'd1);
        cyc(1'b0, 1'b0, '0);
        check("lat_edge2_empty", {31'd0, empty}, 32'd0);
        check("lat_rdata", rdata, 32'h0000_ABCD);
        cyc(1'b0, 1'b1, '0);
        check("single_pop_empty", {31'd0, empty}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, '0);
        end
        check("pop_on_empty", {31'd0, empty}, 32'd1);
        p0 = popped;
        push_word(32'h4444_0001);
        push_word(32'h4444_0002);
        cyc(1'b0, 1'b0, '0);
        drain("after_empty_pop", 10);
        check("after_empty_pops", popped - p0, 32'd2);

        // Asynchronous reset mid-fill discards everything.
        for (int i = 0; i < 10; i++) begin
            push_word(32'h5000_0000 + i);
        end
        shift_in = 1'b0;
        #2;
        res_n = 1'b0;
        #1;
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_full", {31'd0, full}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        res_n = 1'b1;
        p0 = popped;
        push_word(32'h5A5A_0001);
        push_word(32'h5A5A_0002);
        cyc(1'b0, 1'b0, '0);
        check("midrst_head", rdata, 32'h5A5A_0001);
        drain("midrst", 10);
        check("midrst_pops", popped - p0, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
